vector_exec_pipe: RTL and testbench

Parametrised, elastic vector execute pipeline that generalises the processor's 128-bit vector ALU stage into a configurable lane count, lane width and pipeline depth. It adds valid/ready handshaking, back-pressure, flush, signed saturation, a cross-lane reduction and in-flight destination tracking. It sits between the decode/execute register and the memory stage of the vector datapath. Its hazard output replaces ad-hoc `rd_execute` comparisons in hazard detection.

---
 rtl/vector_exec_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_vector_exec_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vector_exec_pipe.sv
// vector_exec_pipe: elastic SIMD execute pipeline with saturation, reduction and hazard tracking.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   in_valid/in_ready          - operation handshake (op, sat, src_a, src_b, rd_in, wre_in)
//   flush                      - drop every in-flight operation at the next edge
//   out_valid/out_ready        - result handshake (result, rd_out, wre_out)
//   query_rs1/query_rs2/hazard - combinational match of source tags against in-flight writers
//   occupancy                  - number of valid pipeline stages
module vector_exec_pipe #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [3:0]                         op,
  input  logic                               sat,
  input  logic [LANES*LANE_W-1:0]            src_a,
  input  logic [LANES*LANE_W-1:0]            src_b,
  input  logic [TAG_W-1:0]                   rd_in,
  input  logic                               wre_in,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*LANE_W-1:0]            result,
  output logic [TAG_W-1:0]                   rd_out,
  output logic                               wre_out,
  input  logic [TAG_W-1:0]                   query_rs1,
  input  logic [TAG_W-1:0]                   query_rs2,
  output logic                               hazard,
  output logic [$clog2(STAGES+1)-1:0]        occupancy
);

  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned SH_W   = $clog2(LANE_W);
  localparam int unsigned SUM_W  = LANE_W + $clog2(LANES) + 1;
  localparam int unsigned OCC_W  = $clog2(STAGES + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MIN  = 4'd9;
  localparam logic [3:0] OP_MAX  = 4'd10;
  localparam logic [3:0] OP_RSUM = 4'd11;
  localparam logic [3:0] OP_MOVA = 4'd12;

  localparam logic [LANE_W-1:0]       SMAX    = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0]       SMIN    = ~SMAX;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

  // Per-lane element operation; RSUM is handled separately on lane 0.
  function automatic logic [LANE_W-1:0] lane_op(input logic [3:0] f, input logic s,
                                                input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
    logic [LANE_W:0]    ext;
    logic [SH_W-1:0]    sh;
    logic [LANE_W-1:0]  r;
    sh  = b[SH_W-1:0];
    // One extra sign bit exposes signed overflow as a mismatch of the top two bits.
    ext = (f == OP_SUB) ? ({a[LANE_W-1], a} - {b[LANE_W-1], b})
                        : ({a[LANE_W-1], a} + {b[LANE_W-1], b});
    r   = '0;
    case (f)
      OP_ADD, OP_SUB: begin
        if (s && (ext[LANE_W] != ext[LANE_W-1])) r = ext[LANE_W] ? SMIN : SMAX;
        else                                      r = ext[LANE_W-1:0];
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = LANE_W'($signed(a) >>> sh);
      OP_MUL:  r = a * b;
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      OP_MOVA: r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic signed [SUM_W-1:0]  sum_full;
  logic [LANE_W-1:0]        rsum_lane;
  logic [DATA_W-1:0]        res_c;

  // Full-precision signed reduction of src_a lanes.
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sum_full = sum_full + SUM_W'($signed(src_a[i*LANE_W +: LANE_W]));
    end
    if (!sat)                  rsum_lane = sum_full[LANE_W-1:0];
    else if (sum_full > SUM_MAX) rsum_lane = SMAX;
    else if (sum_full < SUM_MIN) rsum_lane = SMIN;
    else                       rsum_lane = sum_full[LANE_W-1:0];
  end

  // Lane compute feeding stage 0.
  always_comb begin
    res_c = '0;
    if (op == OP_RSUM) begin
      res_c[LANE_W-1:0] = rsum_lane;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        res_c[i*LANE_W +: LANE_W] = lane_op(op, sat, src_a[i*LANE_W +: LANE_W],
                                            src_b[i*LANE_W +: LANE_W]);
      end
    end
  end

  logic [STAGES-1:0] v_q, v_d, adv;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [TAG_W-1:0]  rd_q   [STAGES];
  logic [TAG_W-1:0]  rd_d   [STAGES];
  logic [STAGES-1:0] wre_q, wre_d;

  // Stage i advances if the output drains or any stage at or after i holds a bubble.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      all_full = all_full & v_q[i];
      adv[i]   = out_ready | ~all_full;
    end
  end

  assign in_ready = !flush && adv[0];

  // Next-state: shift advancing stages, capture accepted op into stage 0.
  always_comb begin
    v_d   = v_q;
    wre_d = wre_q;
    for (int i = 0; i < int'(STAGES); i++) begin
      data_d[i] = data_q[i];
      rd_d[i]   = rd_q[i];
    end
    if (flush) begin
      v_d = '0;
    end else begin
      for (int i = int'(STAGES) - 1; i >= 1; i--) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            data_d[i] = data_q[i-1];
            rd_d[i]   = rd_q[i-1];
            wre_d[i]  = wre_q[i-1];
          end
        end
      end
      if (adv[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = res_c;
          rd_d[0]   = rd_in;
          wre_d[0]  = wre_in;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      wre_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      v_q   <= v_d;
      wre_q <= wre_d;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= data_d[i];
        rd_q[i]   <= rd_d[i];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign result    = data_q[STAGES-1];
  assign rd_out    = rd_q[STAGES-1];
  assign wre_out   = wre_q[STAGES-1];

  // Hazard match and occupancy count over all valid stages.
  always_comb begin
    int unsigned cnt;
    hazard = 1'b0;
    cnt    = 0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (v_q[i]) begin
        cnt = cnt + 1;
        if (wre_q[i] && ((rd_q[i] == query_rs1) || (rd_q[i] == query_rs2))) hazard = 1'b1;
      end
    end
    occupancy = OCC_W'(cnt);
  end

endmodule

// File: tb/tb_vector_exec_pipe.sv
// Directed bench for vector_exec_pipe (16 x 8-bit lanes, 2 stages).
module tb_vector_exec_pipe;

  logic         clk, reset, in_valid, in_ready, sat, wre_in, flush;
  logic         out_valid, out_ready, wre_out, hazard;
  logic [3:0]   op;
  logic [127:0] src_a, src_b, result;
  logic [4:0]   rd_in, rd_out, query_rs1, query_rs2;
  logic [1:0]   occupancy;

  int n_vec = 0;
  int n_err = 0;

  vector_exec_pipe #(.LANES(16), .LANE_W(8), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sat(sat),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .wre_in(wre_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out),
    .wre_out(wre_out), .query_rs1(query_rs1), .query_rs2(query_rs2), .hazard(hazard),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single op through an idle pipe with out_ready=1: result visible two edges after presentation.
  task automatic run_op(input string tag, input logic [3:0] f, input logic s,
                        input logic [127:0] a, input logic [127:0] b, input logic [127:0] exp);
    op = f; sat = s; src_a = a; src_b = b; rd_in = 5'd0; wre_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " early_valid"}, 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    chk({tag, " out_valid"}, 128'(out_valid), 128'd1);
    chk({tag, " result"}, result, exp);
    @(posedge clk); #1;
  endtask

  logic [127:0] ramp;

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 4'd0; sat = 1'b0; src_a = '0; src_b = '0;
    rd_in = '0; wre_in = 1'b0; flush = 1'b0; out_ready = 1'b0; query_rs1 = '0; query_rs2 = '0;
    for (int i = 0; i < 16; i++) ramp[i*8 +: 8] = 8'(i + 1);

    // Reset state
    #1;
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst result", result, 128'd0);
    chk("rst occupancy", 128'(occupancy), 128'd0);
    chk("rst hazard", 128'(hazard), 128'd0);
    chk("rst in_ready", 128'(in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Arithmetic, saturation, reduction, shifts, min/max
    run_op("add_wrap", 4'd0, 1'b0, rep(8'h7F), rep(8'h01), rep(8'h80));
    run_op("add_sat",  4'd0, 1'b1, rep(8'h7F), rep(8'h01), rep(8'h7F));
    run_op("sub_sat",  4'd1, 1'b1, rep(8'h80), rep(8'h01), rep(8'h80));
    run_op("sub_wrap", 4'd1, 1'b0, rep(8'h80), rep(8'h01), rep(8'h7F));
    run_op("and",      4'd2, 1'b0, rep(8'hF0), rep(8'h3C), rep(8'h30));
    run_op("xor",      4'd4, 1'b0, rep(8'hF0), rep(8'h3C), rep(8'hCC));
    run_op("mullo",    4'd8, 1'b0, rep(8'h13), rep(8'h11), rep(8'h43));
    run_op("rsum",     4'd11, 1'b0, ramp, rep(8'h55), {120'd0, 8'h88});
    run_op("rsum_sat", 4'd11, 1'b1, ramp, rep(8'h55), {120'd0, 8'h7F});
    run_op("srl",      4'd6, 1'b0, rep(8'h90), rep(8'h03), rep(8'h12));
    run_op("sra",      4'd7, 1'b0, rep(8'h90), rep(8'h03), rep(8'hF2));
    run_op("sll",      4'd5, 1'b0, rep(8'h90), rep(8'h03), rep(8'h80));
    run_op("min",      4'd9, 1'b0, rep(8'h90), rep(8'h03), rep(8'h90));
    run_op("max",      4'd10, 1'b0, rep(8'h90), rep(8'h03), rep(8'h03));
    run_op("op14",     4'd14, 1'b1, rep(8'hA5), rep(8'h5A), 128'd0);

    // Back-pressure: A and B fill the pipe, C waits
    out_ready = 1'b0; op = 4'd12; sat = 1'b0; src_b = '0; wre_in = 1'b1;
    src_a = rep(8'hA1); rd_in = 5'd1; in_valid = 1'b1;
    #1 chk("bp A ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    src_a = rep(8'hB2); rd_in = 5'd2;
    #1 chk("bp B ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    src_a = rep(8'hC3); rd_in = 5'd3;
    #1;
    chk("bp C blocked", 128'(in_ready), 128'd0);
    chk("bp occupancy", 128'(occupancy), 128'd2);
    chk("bp result A", result, rep(8'hA1));
    chk("bp rd_out A", 128'(rd_out), 128'd1);
    @(posedge clk); #1;
    chk("bp hold result", result, rep(8'hA1));
    chk("bp hold valid", 128'(out_valid), 128'd1);
    chk("bp hold wre", 128'(wre_out), 128'd1);
    out_ready = 1'b1;
    #1 chk("bp C ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp result B", result, rep(8'hB2));
    chk("bp occ full", 128'(occupancy), 128'd2);
    @(posedge clk); #1;
    chk("bp result C", result, rep(8'hC3));
    chk("bp rd_out C", 128'(rd_out), 128'd3);
    chk("bp occ one", 128'(occupancy), 128'd1);
    @(posedge clk); #1;
    chk("bp drained", 128'(out_valid), 128'd0);
    chk("bp occ zero", 128'(occupancy), 128'd0);

    // Hazard and flush
    out_ready = 1'b0; op = 4'd0; src_a = rep(8'h01); src_b = rep(8'h01);
    rd_in = 5'd5; wre_in = 1'b1; query_rs1 = 5'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fl occupancy", 128'(occupancy), 128'd2);
    chk("fl hazard rs1", 128'(hazard), 128'd1);
    query_rs1 = 5'd6; query_rs2 = 5'd7;
    #1 chk("fl no match", 128'(hazard), 128'd0);
    query_rs2 = 5'd5;
    #1 chk("fl hazard rs2", 128'(hazard), 128'd1);
    flush = 1'b1; out_ready = 1'b1;
    #1 chk("fl in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", 128'(out_valid), 128'd0);
    chk("fl occ", 128'(occupancy), 128'd0);
    chk("fl hazard", 128'(hazard), 128'd0);
    @(posedge clk); #1;
    chk("fl nothing taken", 128'(occupancy), 128'd0);

    // Non-writing op does not raise hazard
    out_ready = 1'b0; rd_in = 5'd9; wre_in = 1'b0; query_rs1 = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("wre0 occ", 128'(occupancy), 128'd1);
    chk("wre0 hazard", 128'(hazard), 128'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wre0 drained", 128'(occupancy), 128'd0);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0; op = 4'd12; src_a = rep(8'h5A); rd_in = 5'd3; wre_in = 1'b1;
    query_rs1 = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("ar pre hazard", 128'(hazard), 128'd1);
    chk("ar pre result", result, rep(8'h5A));
    #2 reset = 1'b1;
    #1;
    chk("ar out_valid", 128'(out_valid), 128'd0);
    chk("ar result", result, 128'd0);
    chk("ar occupancy", 128'(occupancy), 128'd0);
    chk("ar hazard", 128'(hazard), 128'd0);
    chk("ar rd_out", 128'(rd_out), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk("ar in_ready", 128'(in_ready), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
